// File: rtl/mwtxsched_pkg.sv
// Shared definitions for the round-robin TX packet scheduler: FSM state
// encoding, default channel/header sizes and header byte-order constants.
package mwtxsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HDR  = 2'd2,
        ST_DATA = 2'd3
    } sched_state_e;

    localparam int NUMCH_DEF    = 8;
    localparam int HDRBEATS_DEF = 4;

    // Header byte order as seen on hdr_sel
    localparam logic [1:0] HDR_SRC_MSB = 2'd0;
    localparam logic [1:0] HDR_SRC_LSB = 2'd1;
    localparam logic [1:0] HDR_DST_MSB = 2'd2;
    localparam logic [1:0] HDR_DST_LSB = 2'd3;

    // Round-robin pointer successor; 3-bit arithmetic wraps 7 -> 0
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/mwrrpick.sv
// Combinational rotating priority encoder: returns the first requester at or
// above ptr, wrapping from the top channel back to channel 0.
module mwrrpick
    import mwtxsched_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [7:0] onehot,
    output logic [2:0] idx,
    output logic       any
);

    // Scan eight candidates starting at ptr; the first hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NUMCH_DEF; i++) begin
            if (!any && req[ptr + 3'(i)]) begin
                any = 1'b1;
                idx = ptr + 3'(i);
            end
        end
        if (any) begin
            onehot = 8'b1 << idx;
        end
    end

endmodule

// File: rtl/mwtxrrscheduler.sv
// Round-robin packet scheduler for the Ethernet MAC hub transmit path.
// Owns the select/enable controls of the TX channel mux: arbitrates among
// eight stream sources, sequences the 4-byte port header and then opens the
// payload window until tlast. Payload data never passes through here.
// Optional feature: define MWTXSCHED_WATCHDOG_EN to bound packets to
// MAXBEATS payload beats (abort pulse + per-channel sticky error).
module mwtxrrscheduler
    import mwtxsched_pkg::*;
#(
    parameter int NUMCH    = NUMCH_DEF,
    parameter int HDRBEATS = HDRBEATS_DEF,
    parameter int MAXBEATS = 1500,
    parameter int CNTW     = 16
) (
    input  logic             dutclk,
    input  logic             reset,
    input  logic [NUMCH-1:0] ch_req,
    input  logic             txbuffer_afull,
    input  logic             beat_vld,
    input  logic             beat_last,
    input  logic             err_clr,
    output logic [NUMCH-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             hdr_vld,
    output logic [1:0]       hdr_sel,
    output logic             data_en,
    output logic             pkt_done,
    output logic             abort,
    output logic [NUMCH-1:0] err_sticky
);

    localparam logic [1:0] HDR_LAST = 2'(HDRBEATS - 1);

    sched_state_e     state_q, state_d;
    logic [NUMCH-1:0] grant_q, grant_d;
    logic [2:0]       grant_idx_q, grant_idx_d;
    logic [1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic             pkt_done_q, pkt_done_d;
    logic             beat_acc;

    logic [7:0]       pick_onehot;
    logic [2:0]       pick_idx;
    logic             pick_any;

`ifdef MWTXSCHED_WATCHDOG_EN
    localparam logic [CNTW-1:0] BEAT_LIMIT = CNTW'(MAXBEATS - 1);

    logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;
    logic             abort_q, abort_d;
    logic [NUMCH-1:0] err_q, err_d;
`endif

    mwrrpick u_pick (
        .req    (ch_req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and mux controls; hdr_vld/data_en are combinational so that
    // almost-full throttles the mux in the same cycle it is raised
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        hdr_cnt_d   = hdr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_done_d  = 1'b0;
        hdr_vld     = 1'b0;
        data_en     = 1'b0;
        beat_acc    = 1'b0;
`ifdef MWTXSCHED_WATCHDOG_EN
        beat_cnt_d  = beat_cnt_q;
        abort_d     = 1'b0;
        // A new error in the same cycle as err_clr is OR-ed in below, so it wins
        err_d       = err_q & ~{NUMCH{err_clr}};
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!txbuffer_afull) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (pick_any) begin
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    hdr_cnt_d   = HDR_SRC_MSB;
`ifdef MWTXSCHED_WATCHDOG_EN
                    beat_cnt_d  = '0;
`endif
                    state_d     = ST_HDR;
                end
            end

            ST_HDR: begin
                hdr_vld = !txbuffer_afull;
                if (hdr_vld) begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        hdr_cnt_d = HDR_SRC_MSB;
                        state_d   = ST_DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                    end
                end
            end

            ST_DATA: begin
                data_en  = !txbuffer_afull;
                // Only beats the mux could legally accept are counted
                beat_acc = beat_vld & data_en;
                if (beat_acc) begin
`ifdef MWTXSCHED_WATCHDOG_EN
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
`endif
                    if (beat_last) begin
                        pkt_done_d  = 1'b1;
                        rr_ptr_d    = rr_next(grant_idx_q);
                        grant_d     = '0;
                        grant_idx_d = '0;
                        state_d     = ST_IDLE;
                    end
`ifdef MWTXSCHED_WATCHDOG_EN
                    // tlast on the limit beat takes the branch above instead
                    else if (beat_cnt_q == BEAT_LIMIT) begin
                        abort_d            = 1'b1;
                        err_d[grant_idx_q] = 1'b1;
                        rr_ptr_d           = rr_next(grant_idx_q);
                        grant_d            = '0;
                        grant_idx_d        = '0;
                        state_d            = ST_IDLE;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, counters and registered pulses
    always_ff @(posedge dutclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            hdr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            hdr_cnt_q   <= hdr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

`ifdef MWTXSCHED_WATCHDOG_EN
    // Watchdog beat counter, abort pulse and sticky per-channel errors
    always_ff @(posedge dutclk) begin
        if (reset) begin
            beat_cnt_q <= '0;
            abort_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

    assign abort      = abort_q;
    assign err_sticky = err_q;
`else
    // Packets are unbounded without the watchdog
    logic unused_wd;
    assign unused_wd  = ^{err_clr, CNTW'(MAXBEATS)};
    assign abort      = 1'b0;
    assign err_sticky = '0;
`endif

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign hdr_sel   = hdr_cnt_q;
    assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_mwtxrrscheduler.sv
// Self-checking bench for mwtxrrscheduler: a cycle table for the header/afull
// corner cases, then scoreboarded packet sequences for arbitration order.
module tb_mwtxrrscheduler;

    localparam int TB_MAXBEATS = 8;

    logic       dutclk = 1'b0;
    logic       reset;
    logic [7:0] ch_req;
    logic       txbuffer_afull;
    logic       beat_vld;
    logic       beat_last;
    logic       err_clr;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       hdr_vld;
    logic [1:0] hdr_sel;
    logic       data_en;
    logic       pkt_done;
    logic       abort;
    logic [7:0] err_sticky;

    mwtxrrscheduler #(
        .NUMCH    (8),
        .HDRBEATS (4),
        .MAXBEATS (TB_MAXBEATS),
        .CNTW     (16)
    ) dut (
        .dutclk         (dutclk),
        .reset          (reset),
        .ch_req         (ch_req),
        .txbuffer_afull (txbuffer_afull),
        .beat_vld       (beat_vld),
        .beat_last      (beat_last),
        .err_clr        (err_clr),
        .grant          (grant),
        .grant_idx      (grant_idx),
        .hdr_vld        (hdr_vld),
        .hdr_sel        (hdr_sel),
        .data_en        (data_en),
        .pkt_done       (pkt_done),
        .abort          (abort),
        .err_sticky     (err_sticky)
    );

    always #5 dutclk = ~dutclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge dutclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dutclk);
        #1;
    endtask

    // ---------------- cycle table ----------------
    typedef struct packed {
        logic [7:0]  req;
        logic        af;
        logic        bv;
        logic        bl;
        logic [16:0] exp; // {grant, grant_idx, hdr_vld, hdr_sel, data_en, pkt_done, abort}
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic [7:0] req, input logic af, input logic bv,
                                input logic bl, input logic [7:0] g, input logic [2:0] gi,
                                input logic hv, input logic [1:0] hs, input logic de,
                                input logic done);
        vec_t v;
        v.req = req;
        v.af  = af;
        v.bv  = bv;
        v.bl  = bl;
        v.exp = {g, gi, hv, hs, de, done, 1'b0};
        return v;
    endfunction

    function automatic logic [16:0] obs();
        return {grant, grant_idx, hdr_vld, hdr_sel, data_en, pkt_done, abort};
    endfunction

    // ---------------- scoreboard monitor ----------------
    bit   mon_en = 1'b0;
    int   exp_q[$];
    int   hcnt = 0;
    logic de_prev = 1'b0;
    int   done_cnt = 0;
    int   abort_cnt = 0;

    always @(negedge dutclk) begin
        if (mon_en && !reset) begin
            if (hdr_vld) begin
                if (hdr_sel == 2'd0) begin
                    chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        int e;
                        e = exp_q.pop_front();
                        chk("sb_grant_idx", 32'(grant_idx), 32'(e));
                        chk("sb_grant_onehot", 32'(grant), 32'(8'b1 << e));
                    end
                end
                chk("hdr_sel_order", 32'(hdr_sel), 32'(hcnt));
                hcnt++;
            end
            if (data_en && !de_prev) begin
                chk("hdr_beats", 32'(hcnt), 32'd4);
                hcnt = 0;
            end
            if (pkt_done) done_cnt++;
            if (abort) abort_cnt++;
            de_prev = data_en;
        end else begin
            de_prev = 1'b0;
            hcnt    = 0;
        end
    end

    task automatic wait_data(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (data_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_data_timeout"}, 32'(ok), 32'd1);
    endtask

    // Drives n accepted beats; tlast on the final one when 'last' is set
    task automatic send_beats(input int n, input bit last, input bit chk_g, input logic [7:0] g);
        for (int k = 0; k < n; k++) begin
            beat_vld  = 1'b1;
            beat_last = last && (k == n - 1);
            if (chk_g) chk("grant_locked", 32'(grant), 32'(g));
            tick();
        end
        beat_vld  = 1'b0;
        beat_last = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int last_cyc;
        int exp_done;
        int exp_abort;
        exp_done  = 0;
        exp_abort = 0;
        last_cyc  = 0;

        reset = 1'b1;
        ch_req = '0;
        txbuffer_afull = 1'b0;
        beat_vld = 1'b0;
        beat_last = 1'b0;
        err_clr = 1'b0;

        // Rows: afull stall in header, afull + stray beat in DATA, beat in ARB ignored
        tbl[0]  = mk(8'h02, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 0);
        tbl[1]  = mk(8'h02, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 0);
        tbl[2]  = mk(8'h02, 0, 0, 0, 8'h02, 3'd1, 1, 2'd0, 0, 0);
        tbl[3]  = mk(8'h02, 0, 0, 0, 8'h02, 3'd1, 1, 2'd1, 0, 0);
        tbl[4]  = mk(8'h02, 1, 0, 0, 8'h02, 3'd1, 0, 2'd2, 0, 0);
        tbl[5]  = mk(8'h02, 1, 0, 0, 8'h02, 3'd1, 0, 2'd2, 0, 0);
        tbl[6]  = mk(8'h02, 1, 0, 0, 8'h02, 3'd1, 0, 2'd2, 0, 0);
        tbl[7]  = mk(8'h02, 0, 0, 0, 8'h02, 3'd1, 1, 2'd2, 0, 0);
        tbl[8]  = mk(8'h02, 0, 0, 0, 8'h02, 3'd1, 1, 2'd3, 0, 0);
        tbl[9]  = mk(8'h02, 0, 1, 0, 8'h02, 3'd1, 0, 2'd0, 1, 0);
        tbl[10] = mk(8'h02, 0, 1, 1, 8'h02, 3'd1, 0, 2'd0, 1, 0);
        tbl[11] = mk(8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 1);
        tbl[12] = mk(8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 0);
        tbl[13] = mk(8'h00, 1, 1, 1, 8'h00, 3'd0, 0, 2'd0, 0, 0);
        tbl[14] = mk(8'h08, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 0);
        tbl[15] = mk(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 2'd0, 0, 0);
        tbl[16] = mk(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 2'd1, 0, 0);
        tbl[17] = mk(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 2'd2, 0, 0);
        tbl[18] = mk(8'h08, 0, 0, 0, 8'h08, 3'd3, 1, 2'd3, 0, 0);
        tbl[19] = mk(8'h08, 1, 1, 1, 8'h08, 3'd3, 0, 2'd0, 0, 0);
        tbl[20] = mk(8'h08, 0, 1, 1, 8'h08, 3'd3, 0, 2'd0, 1, 0);
        tbl[21] = mk(8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 2'd0, 0, 1);

        tick();
        tick();
        chk("reset_outputs", 32'(obs()), 32'd0);
        chk("reset_err_sticky", 32'(err_sticky), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            ch_req         = tbl[i].req;
            txbuffer_afull = tbl[i].af;
            beat_vld       = tbl[i].bv;
            beat_last      = tbl[i].bl;
            #2;
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
            @(posedge dutclk);
            #1;
        end
        ch_req = '0;
        txbuffer_afull = 1'b0;
        beat_vld = 1'b0;
        beat_last = 1'b0;

        // All channels requesting: order 0..7,0 with minimum 6-cycle overhead
        do_reset();
        mon_en = 1'b1;
        for (int p = 0; p < 9; p++) exp_q.push_back(p % 8);
        ch_req = 8'hFF;
        for (int p = 0; p < 9; p++) begin
            wait_data($sformatf("rr%0d", p));
            if (p > 0) chk("overhead_cycles", 32'(cyc - last_cyc), 32'd7);
            beat_vld = 1'b1;
            beat_last = 1'b0;
            tick();
            beat_last = 1'b1;
            last_cyc = cyc;
            tick();
            beat_vld = 1'b0;
            beat_last = 1'b0;
            exp_done++;
        end
        ch_req = '0;
        tick();
        tick();
        chk("rr_done_count", 32'(done_cnt), 32'(exp_done));

        // ch2 drops its request mid-DATA while ch0 waits: grant stays on ch2
        exp_q.push_back(2);
        ch_req = 8'h05;
        wait_data("drop");
        ch_req = 8'h01;
        send_beats(3, 1'b1, 1'b1, 8'h04);
        exp_done++;
        exp_q.push_back(0);
        wait_data("after_drop");
        send_beats(1, 1'b1, 1'b0, 8'h00);
        exp_done++;

        // Only ch5: grant ch5, then again with rr_ptr=6 (wrap), then ch6 beats ch5
        exp_q.push_back(5);
        ch_req = 8'h20;
        wait_data("ch5a");
        send_beats(1, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(5);
        wait_data("ch5_wrap");
        send_beats(1, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(6);
        ch_req = 8'h60;
        wait_data("ptr6");
        ch_req = 8'h00;
        send_beats(1, 1'b1, 1'b0, 8'h00);
        exp_done += 3;

        // Reset during DATA on ch4; next arbitration restarts from ch0
        exp_q.push_back(4);
        ch_req = 8'h10;
        wait_data("ch4");
        send_beats(1, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        tick();
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_data_en", 32'(data_en), 32'd0);
        chk("rst_mid_outputs", 32'(obs()), 32'd0);
        reset = 1'b0;
        exp_q.push_back(0);
        ch_req = 8'hFF;
        wait_data("post_rst");
        ch_req = 8'h00;
        send_beats(1, 1'b1, 1'b0, 8'h00);
        exp_done++;
        tick();

        // Watchdog behaviour on ch3 with an 8-beat limit
        do_reset();
        exp_q.push_back(3);
        ch_req = 8'h08;
        wait_data("wd1");
        ch_req = 8'h00;
`ifdef MWTXSCHED_WATCHDOG_EN
        send_beats(7, 1'b0, 1'b0, 8'h00);
        beat_vld = 1'b1;
        err_clr  = 1'b1;
        tick();
        beat_vld = 1'b0;
        err_clr  = 1'b0;
        chk("wd_abort_pulse", 32'(abort), 32'd1);
        chk("wd_no_done", 32'(pkt_done), 32'd0);
        chk("wd_err_set", 32'(err_sticky), 32'h08);
        exp_abort++;
        tick();
        chk("wd_abort_one_cycle", 32'(abort), 32'd0);
        chk("wd_err_hold", 32'(err_sticky), 32'h08);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_err_clr", 32'(err_sticky), 32'h00);
        exp_q.push_back(4);
        ch_req = 8'h18;
        wait_data("wd2");
        ch_req = 8'h00;
        send_beats(8, 1'b1, 1'b0, 8'h00);
        chk("wd_last_wins_done", 32'(pkt_done), 32'd1);
        chk("wd_last_wins_abort", 32'(abort), 32'd0);
        chk("wd_last_wins_err", 32'(err_sticky), 32'h00);
        exp_done++;
`else
        send_beats(TB_MAXBEATS + 2, 1'b0, 1'b0, 8'h00);
        chk("nowd_still_data", 32'(data_en), 32'd1);
        chk("nowd_abort", 32'(abort), 32'd0);
        chk("nowd_err", 32'(err_sticky), 32'd0);
        send_beats(1, 1'b1, 1'b0, 8'h00);
        chk("nowd_done", 32'(pkt_done), 32'd1);
        exp_done++;
`endif
        tick();
        tick();

        chk("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_done", 32'(done_cnt), 32'(exp_done));
        chk("total_abort", 32'(abort_cnt), 32'(exp_abort));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mwtxrrscheduler.md
# mwtxrrscheduler

Round-robin packet scheduler for the Ethernet MAC hub transmit path. It decides which of eight AXI-Stream source channels owns the shared TX buffer. It sequences the 4-byte port header followed by the payload, and enforces a maximum packet length. It drives the select and enable controls of the downstream TX channel mux and never touches payload data itself.

## Interface
- NUMCH, 8, number of requesting channels (fixed at 8 for this revision)
- HDRBEATS, 4, header beats (srcport/dstport bytes) emitted before payload
- MAXBEATS, 1500, payload beat limit per packet, used by the watchdog
- CNTW, 16, width of the beat counter; MAXBEATS must be < 2^CNTW

Ports:
- dutclk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ch_req  in  NUMCH  per-channel tvalid, used as the request
- txbuffer_afull  in  1  TX buffer almost-full
- beat_vld  in  1  payload beat accepted by the mux (tvalid & tready on the granted channel)
- beat_last  in  1  tlast of the accepted beat, qualified by beat_vld
- err_clr  in  1  single-cycle pulse; clears err_sticky
- grant  out  NUMCH  one-hot owner, held from HDR through DATA
- grant_idx  out  3  binary index of grant
- hdr_vld  out  1  write the header byte selected by hdr_sel this cycle
- hdr_sel  out  2  header byte index; 0 = srcport MSB ... 3 = dstport LSB
- data_en  out  1  mux may assert tready on the granted channel
- pkt_done  out  1  one-cycle pulse when a packet completes normally
- abort  out  1  one-cycle pulse when the watchdog ends a packet
- err_sticky  out  NUMCH  per-channel sticky watchdog error

## Operation
- States: IDLE, ARB, HDR, DATA.
- IDLE: all outputs are low and grant is 0. Move to ARB when txbuffer_afull = 0.
- ARB:
  - If ch_req != 0, pick the first requester at or above rr_ptr, wrapping 7 -> 0.
  - Register grant and grant_idx, clear hdr_cnt and beat_cnt, then go to HDR.
  - If ch_req = 0, stay in ARB.
- HDR:
  - hdr_vld = !txbuffer_afull; hdr_sel = hdr_cnt; hdr_cnt increments on hdr_vld.
  - Move to DATA on the hdr_vld cycle where hdr_cnt = HDRBEATS-1.
- DATA:
  - data_en = !txbuffer_afull; beat_cnt increments on beat_vld.
  - beat_vld & beat_last: pulse pkt_done, set rr_ptr = grant_idx+1 mod 8, go to IDLE.
- Grant is locked from ARB exit to DATA exit. Deasserting ch_req mid-packet has no effect on grant. Requests from other channels are ignored until the next ARB.
- rr_ptr advances only on packet completion or abort. With all channels requesting continuously, the grant order is 0,1,...,7,0.
- Reset mid-packet: state goes to IDLE, rr_ptr = 0, counters = 0, err_sticky = 0, all outputs low on the next cycle.

## Timing
- Reset values: grant=0, grant_idx=0, hdr_vld=0, hdr_sel=0, data_en=0, pkt_done=0, abort=0, err_sticky=0.
- All outputs are registered except hdr_vld and data_en, which are combinational from state and txbuffer_afull. This gives zero-cycle afull back-pressure.
- Latency from the ch_req edge in ARB to grant valid is 1 cycle. The first hdr_vld follows in the next cycle if afull = 0.
- Minimum packet overhead is IDLE + ARB + HDRBEATS = 6 cycles between the last beat of one packet and the first payload beat of the next.
- When txbuffer_afull is high in HDR or DATA, the block holds its state and hdr_cnt, and hdr_vld and data_en are 0.
- beat_vld outside DATA is ignored.

## Configuration
- MWTXSCHED_WATCHDOG_EN defined:
  - In DATA, if beat_cnt reaches MAXBEATS with no beat_last, pulse abort, set err_sticky[grant_idx], advance rr_ptr, and go to IDLE.
  - If beat_last and the limit are hit in the same cycle, beat_last wins: pkt_done, no error.
  - err_clr clears err_sticky. If err_clr and a new error occur in the same cycle, the set wins.
- MWTXSCHED_WATCHDOG_EN undefined: beat_cnt and the abort logic are removed; abort and err_sticky are tied to 0; packets are unbounded.

## Structure
- Shared package mwtxsched_pkg holds:
  - the state encoding (IDLE=0, ARB=1, HDR=2, DATA=3, 2 bits);
  - the NUMCH and HDRBEATS defaults;
  - the hdr_sel byte-order constants.
- Sub-module mwrrpick: a combinational rotating priority encoder. It takes (req[7:0], ptr[2:0]) and returns (onehot[7:0], idx[2:0], any), and is instantiated once.

## Test plan
- All 8 channels request continuously, 2-beat packets -> grant_idx sequence 0,1,2,...,7,0; one pkt_done per packet; 4 hdr_vld beats with hdr_sel 0,1,2,3 before each data_en window.
- Only ch5 requests, rr_ptr=6 -> ch5 granted (wrap-around); next rr_ptr=6.
- txbuffer_afull asserted for 3 cycles after hdr_sel=1 -> hdr_vld low for those 3 cycles, then resumes at hdr_sel=2 with no skipped or repeated byte.
- ch2 drops ch_req mid-DATA while ch0 requests -> grant stays 0x04 until beat_last on ch2.
- Watchdog enabled with MAXBEATS=8: ch3 sends 8 beats without tlast -> abort on beat 8, err_sticky=0x08; err_clr -> 0x00. With beat_last on beat 8 instead -> pkt_done, no error.
- Reset asserted during DATA on ch4 -> next cycle grant=0, data_en=0, state IDLE; the next arbitration starts from ch0.
